// File: rtl/reset_ctrl_pkg.sv
// Shared types and defaults for the reset sequencer: FSM state encoding,
// default interval lengths and the saturating lock-loss counter helper.
package reset_ctrl_pkg;

    localparam int unsigned LockWaitDef = 16;
    localparam int unsigned SoftHoldDef = 8;
    localparam int unsigned CntWDef     = 8;
    localparam logic [3:0]  LostMax     = 4'd15;

    typedef enum logic [1:0] {
        StWaitLock = 2'd0,
        StStable   = 2'd1,
        StRun      = 2'd2,
        StSoft     = 2'd3
    } state_e;

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == LostMax) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser with asynchronous active-low clear.
module sync_2ff (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/reset_ctrl.sv
// Chip-level reset sequencer: releases sys_reset_ after a stable lock interval,
// re-asserts it on lock loss, stretches soft-reset requests, counts lock losses.
module reset_ctrl
    import reset_ctrl_pkg::*;
#(
    parameter int unsigned LOCK_WAIT = LockWaitDef,
    parameter int unsigned SOFT_HOLD = SoftHoldDef,
    parameter int unsigned CNT_W     = CntWDef
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       locked,
    input  logic       soft_rst_req,
    output logic       sys_reset_,
    output logic       rst_done,
    output logic [3:0] lost_cnt
);

    localparam logic [CNT_W-1:0] LockLast = CNT_W'(LOCK_WAIT - 1);
    localparam logic [CNT_W-1:0] SoftLast = CNT_W'(SOFT_HOLD - 1);

    logic             w_locked_s;
    state_e           r_state;
    state_e           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_sys_rst_n;
    logic             w_sys_rst_n_nxt;
    logic             r_rst_done;
    logic             w_rst_done_nxt;
    logic [3:0]       r_lost_cnt;
    logic [3:0]       w_lost_cnt_nxt;

    sync_2ff u_lock_sync (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_d     (locked),
        .o_q     (w_locked_s)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_lost_cnt_nxt = r_lost_cnt;
        unique case (r_state)
            StWaitLock: begin
                if (w_locked_s) begin
                    w_state_nxt = StStable;
                    w_cnt_nxt   = '0;
                end
            end
            StStable: begin
                // Losing lock before release is not counted as a loss.
                if (!w_locked_s) begin
                    w_state_nxt = StWaitLock;
                end else if (r_cnt == LockLast) begin
                    w_state_nxt = StRun;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            StRun: begin
                if (!w_locked_s) begin
                    w_state_nxt    = StWaitLock;
                    w_lost_cnt_nxt = sat_inc4(r_lost_cnt);
                end else if (soft_rst_req) begin
                    w_state_nxt = StSoft;
                    w_cnt_nxt   = '0;
                end
            end
            StSoft: begin
                if (!w_locked_s) begin
                    w_state_nxt    = StWaitLock;
                    w_lost_cnt_nxt = sat_inc4(r_lost_cnt);
                end else if (r_cnt == SoftLast) begin
                    w_state_nxt = StRun;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = StWaitLock;
            end
        endcase

        // Outputs track the next state so they change on the same edge as the FSM.
        w_sys_rst_n_nxt = (w_state_nxt == StRun);
        w_rst_done_nxt  = w_sys_rst_n_nxt && (r_state != StRun);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= StWaitLock;
            r_cnt       <= '0;
            r_sys_rst_n <= 1'b0;
            r_rst_done  <= 1'b0;
            r_lost_cnt  <= 4'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_sys_rst_n <= w_sys_rst_n_nxt;
            r_rst_done  <= w_rst_done_nxt;
            r_lost_cnt  <= w_lost_cnt_nxt;
        end
    end

    assign sys_reset_ = r_sys_rst_n;
    assign rst_done   = r_rst_done;
    assign lost_cnt   = r_lost_cnt;

endmodule

// File: tb/tb_reset_ctrl.sv
// Scoreboard bench for reset_ctrl: stimulus pushes time-stamped expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_reset_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       locked;
    logic       soft_rst_req;
    logic       sys_reset_;
    logic       rst_done;
    logic [3:0] lost_cnt;

    logic       reset1;
    logic       locked1;
    logic       soft1;
    logic       sys_reset_1;
    logic       rst_done1;
    logic [3:0] lost_cnt1;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit done1    = 1'b0;

    typedef struct {
        int    cyc;
        int    sel;
        string tag;
        int    val;
    } sb_t;

    sb_t sb[$];
    sb_t mon_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    reset_ctrl u_dut (
        .clk          (clk),
        .reset        (reset),
        .locked       (locked),
        .soft_rst_req (soft_rst_req),
        .sys_reset_   (sys_reset_),
        .rst_done     (rst_done),
        .lost_cnt     (lost_cnt)
    );

    reset_ctrl #(
        .LOCK_WAIT (1),
        .SOFT_HOLD (1),
        .CNT_W     (8)
    ) u_dut1 (
        .clk          (clk),
        .reset        (reset1),
        .locked       (locked1),
        .soft_rst_req (soft1),
        .sys_reset_   (sys_reset_1),
        .rst_done     (rst_done1),
        .lost_cnt     (lost_cnt1)
    );

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", tag, cyc, obs, exp);
        end
    endtask

    function automatic int obs_of(input int sel);
        case (sel)
            0:       return int'(sys_reset_);
            1:       return int'(rst_done);
            2:       return int'(lost_cnt);
            3:       return int'(sys_reset_1);
            default: return int'(rst_done1);
        endcase
    endfunction

    task automatic expect_at(input int c, input int sel, input string tag, input int val);
        sb_t e;
        int  i;
        e.cyc = c;
        e.sel = sel;
        e.tag = tag;
        e.val = val;
        i = 0;
        while (i < sb.size() && sb[i].cyc <= c) i++;
        sb.insert(i, e);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Full lock sequence: locked high before edge c+1 releases at edge c+19.
    task automatic expect_release(input int c, input string tag);
        expect_at(c + 2,  0, {tag, "_sys_early"}, 0);
        expect_at(c + 18, 0, {tag, "_sys_hold"}, 0);
        expect_at(c + 18, 1, {tag, "_done_pre"}, 0);
        expect_at(c + 19, 0, {tag, "_sys_rel"}, 1);
        expect_at(c + 19, 1, {tag, "_done"}, 1);
        expect_at(c + 20, 1, {tag, "_done_post"}, 0);
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            mon_e = sb.pop_front();
            check_val(mon_e.tag, obs_of(mon_e.sel), mon_e.val);
        end
    end

    initial begin
        int c;
        int r;
        reset        = 1'b0;
        locked       = 1'b0;
        soft_rst_req = 1'b0;
        #1;
        check_val("por_sys", int'(sys_reset_), 0);
        check_val("por_done", int'(rst_done), 0);
        check_val("por_lost", int'(lost_cnt), 0);
        step(5);

        // Power-up
        reset  = 1'b1;
        locked = 1'b1;
        c = cyc;
        expect_release(c, "pwr");
        expect_at(c + 19, 2, "pwr_lost", 0);
        step(22);

        // Unstable lock after a fresh reset
        locked = 1'b0;
        reset  = 1'b0;
        step(2);
        reset = 1'b1;
        step(2);
        c = cyc;
        locked = 1'b1;
        expect_at(c + 19, 0, "unst_no_early", 0);
        expect_release(c + 11, "unst");
        expect_at(c + 30, 2, "unst_lost", 0);
        step(10);
        locked = 1'b0;
        step(1);
        locked = 1'b1;
        step(21);

        // Soft reset with a redundant second pulse during the hold
        c = cyc;
        soft_rst_req = 1'b1;
        expect_at(c + 1, 0, "soft_low_first", 0);
        expect_at(c + 8, 0, "soft_low_last", 0);
        expect_at(c + 8, 1, "soft_done_pre", 0);
        expect_at(c + 9, 0, "soft_rel", 1);
        expect_at(c + 9, 1, "soft_done", 1);
        expect_at(c + 10, 0, "soft_stay", 1);
        step(1);
        soft_rst_req = 1'b0;
        step(2);
        soft_rst_req = 1'b1;
        step(1);
        soft_rst_req = 1'b0;
        step(8);

        // Lock loss in RUN
        c = cyc;
        locked = 1'b0;
        expect_at(c + 2, 0, "loss_run_sys_pre", 1);
        expect_at(c + 2, 2, "loss_run_lost_pre", 0);
        expect_at(c + 3, 0, "loss_run_sys", 0);
        expect_at(c + 3, 2, "loss_run_lost", 1);
        step(3);
        locked = 1'b1;
        r = cyc;
        expect_release(r, "relock1");
        step(22);

        // Lock loss in SOFT
        c = cyc;
        soft_rst_req = 1'b1;
        expect_at(c + 4, 2, "loss_soft_lost_pre", 1);
        expect_at(c + 5, 2, "loss_soft_lost", 2);
        expect_at(c + 5, 0, "loss_soft_sys", 0);
        expect_at(c + 9, 1, "loss_soft_no_done", 0);
        expect_at(c + 9, 0, "loss_soft_no_rel", 0);
        step(1);
        soft_rst_req = 1'b0;
        step(1);
        locked = 1'b0;
        step(4);
        locked = 1'b1;
        r = cyc;
        expect_release(r, "relock2");
        step(22);

        // Repeated losses up to saturation (20 total)
        for (int i = 0; i < 18; i++) begin
            c = cyc;
            locked = 1'b0;
            expect_at(c + 3, 2, "sat_lost", (3 + i > 15) ? 15 : 3 + i);
            expect_at(c + 22, 0, "sat_rel", 1);
            step(3);
            locked = 1'b1;
            step(20);
        end

        // Asynchronous reset between edges while in RUN
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_val("mid_rst_sys", int'(sys_reset_), 0);
        check_val("mid_rst_done", int'(rst_done), 0);
        check_val("mid_rst_lost", int'(lost_cnt), 0);
        step(2);
        reset = 1'b1;
        c = cyc;
        expect_release(c, "mid_rst");
        expect_at(c + 19, 2, "mid_rst_lost_after", 0);
        step(22);

        for (int i = 0; i < 200 && !done1; i++) step(1);
        check_val("dut1_finished", int'(done1), 1);
        for (int i = 0; i < 50 && sb.size() > 0; i++) step(1);
        check_val("sb_drain", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Minimum-interval instance: release at edge 4, single-cycle soft hold.
    initial begin
        int c;
        int d;
        reset1  = 1'b0;
        locked1 = 1'b0;
        soft1   = 1'b0;
        step(3);
        c = cyc;
        reset1  = 1'b1;
        locked1 = 1'b1;
        expect_at(c + 3, 3, "p1_sys_hold", 0);
        expect_at(c + 4, 3, "p1_sys_rel", 1);
        expect_at(c + 4, 4, "p1_done", 1);
        expect_at(c + 5, 4, "p1_done_post", 0);
        step(8);
        d = cyc;
        soft1 = 1'b1;
        expect_at(d + 1, 3, "p1_soft_low", 0);
        expect_at(d + 1, 4, "p1_soft_done_pre", 0);
        expect_at(d + 2, 3, "p1_soft_rel", 1);
        expect_at(d + 2, 4, "p1_soft_done", 1);
        expect_at(d + 3, 4, "p1_soft_done_post", 0);
        step(1);
        soft1 = 1'b0;
        step(5);
        done1 = 1'b1;
    end

endmodule
